// File: rtl/data_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-ported data memory.
// Requester 0 is the CPU core, requester 1 is the debug/loader engine.
// The winning command is registered (stage A) and drives the memory. A read's
// data is captured at the end of stage A and returned in stage B, tagged with
// its owner. Writes that land in RO_LO..RO_HI are dropped and flagged.
//
// Handshake: a command transfers in the cycle where req_i=1 and gnt_i=1. The
// requester holds its command stable while req_i=1 and gnt_i=0. gnt_i depends
// only on req0, req1 and the last-grant pointer, so it never waits on a grant.
module data_mem_arbiter #(
    parameter int                ADDR_W = 8,
    parameter int                DATA_W = 8,
    parameter logic [ADDR_W-1:0] RO_LO  = ADDR_W'(0),
    parameter logic [ADDR_W-1:0] RO_HI  = ADDR_W'(1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              wr_err,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [ADDR_W-1:0] mem_read_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    // Width of the protected window. The range test subtracts RO_LO with
    // wrap-around, so addresses below RO_LO become large and fall outside.
    localparam logic [ADDR_W-1:0] RO_SPAN = RO_HI - RO_LO;

    logic              last;       // requester that won the most recent transfer
    logic              xfer;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              stage_a_v;
    logic              stage_a_we;
    logic              stage_a_id;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] ro_offset;
    logic              ro_hit;

    logic              stage_b_v;
    logic              rsp_id_q;
    logic [DATA_W-1:0] rsp_data_q;

    // Grant: a lone requester always wins; on a tie the one that is not `last` wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            gnt0 = req0 && (!req1 || last);
            gnt1 = req1 && (!req0 || !last);
        end
    end

    // Select the winning command for capture into stage A.
    always_comb begin
        xfer      = gnt0 || gnt1;
        sel_we    = gnt1 ? we1    : we0;
        sel_addr  = gnt1 ? addr1  : addr0;
        sel_wdata = gnt1 ? wdata1 : wdata0;
    end

    // Last-grant pointer: follows the winner, holds when nothing transfers.
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= 1'b1;
        end else if (gnt0) begin
            last <= 1'b0;
        end else if (gnt1) begin
            last <= 1'b1;
        end
    end

    // Stage A register. The read address only moves on a read so the memory
    // keeps seeing the previous read address during idle or write cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_a_v  <= 1'b0;
            stage_a_we <= 1'b0;
            stage_a_id <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_addr_q  <= '0;
        end else begin
            stage_a_v <= xfer;
            if (xfer) begin
                stage_a_we <= sel_we;
                stage_a_id <= gnt1;
                if (sel_we) begin
                    wr_addr_q <= sel_addr;
                    wr_data_q <= sel_wdata;
                end else begin
                    rd_addr_q <= sel_addr;
                end
            end
        end
    end

    // Protected-window check and memory drive. A reset in the stage-A cycle
    // must not let the pending write reach the memory on that edge.
    always_comb begin
        ro_offset         = wr_addr_q - RO_LO;
        ro_hit            = (ro_offset <= RO_SPAN);
        mem_write_enable  = !reset && stage_a_v && stage_a_we && !ro_hit;
        wr_err            = !reset && stage_a_v && stage_a_we && ro_hit;
        mem_write_address = wr_addr_q;
        mem_write_data    = wr_data_q;
        mem_read_address  = rd_addr_q;
    end

    // Stage B register: capture read data at the end of stage A, reads only.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_b_v  <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            stage_b_v <= stage_a_v && !stage_a_we;
            if (stage_a_v && !stage_a_we) begin
                rsp_id_q   <= stage_a_id;
                rsp_data_q <= mem_read_data;
            end
        end
    end

    // Response outputs; no response is presented while reset is held.
    always_comb begin
        rsp_valid = stage_b_v && !reset;
        rsp_id    = rsp_id_q;
        rsp_data  = rsp_data_q;
    end

endmodule
